mc_decoder: RTL and testbench

MC_DECODER -- requirements
Module: mc_decoder

---
 rtl/mc_decoder_pkg.sv | 34 +++
 rtl/mc_aludec.sv | 30 +++
 rtl/mc_decoder.sv | 122 ++++++++++++
 tb/tb_mc_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mc_decoder_pkg.sv
// Shared encodings for the multicycle control path: FSM states, op classes,
// data-processing command codes and ALU control codes.
package mc_decoder_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the data-processing command to an ALU operation and
// the flag-write request; idle (ADD, no flags) outside execute states.
module mc_aludec
   import mc_decoder_pkg::*;
(
   input  logic       aluop,
   input  logic [5:0] funct,
   output logic [1:0] alucontrol,
   output logic [1:0] flagw
);

   logic s_bit;
   assign s_bit = funct[0];

   // Logical ops leave C and V alone, so only arithmetic updates the CV group.
   always_comb begin
      alucontrol = ALU_ADD;
      flagw      = 2'b00;
      if (aluop) begin
         case (funct[4:1])
            CMD_ADD: begin alucontrol = ALU_ADD; flagw = {s_bit, s_bit}; end
            CMD_SUB: begin alucontrol = ALU_SUB; flagw = {s_bit, s_bit}; end
            CMD_AND: begin alucontrol = ALU_AND; flagw = {s_bit, 1'b0};  end
            CMD_ORR: begin alucontrol = ALU_ORR; flagw = {s_bit, 1'b0};  end
            default: begin alucontrol = ALU_ADD; flagw = 2'b00;          end
         endcase
      end
   end

endmodule

// File: rtl/mc_decoder.sv
// Multicycle main decoder: Moore FSM sequencing fetch/decode/execute plus
// the ALU decoder and the PC-source request.
module mc_decoder
   import mc_decoder_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   output logic       irWrite,
   output logic       nextPC,
   output logic       regW,
   output logic       memW,
   output logic       PCS,
   output logic [1:0] flagW,
   output logic       adrSrc,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] resultSrc,
   output logic [1:0] aluControl,
   output logic [1:0] immSrc,
   output logic [1:0] regSrc
);

   logic [STATE_W-1:0] state_reg;
   state_t             state;
   state_t             state_next;

   logic       ir_w, pc_w, reg_w, mem_w, branch, aluop;
   logic [1:0] flag_w;

   assign state = state_t'(state_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= STATE_W'(S_FETCH);
      else        state_reg <= STATE_W'(state_next);
   end

   // Only DECODE and MEMADR look at the instruction fields.
   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_MEM:  state_next = S_MEMADR;
               OP_DP:   state_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   state_next = S_BRANCH;
               default: state_next = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next = S_MEMWB;
         S_EXECUTER: state_next = S_ALUWB;
         S_EXECUTEI: state_next = S_ALUWB;
         default:    state_next = S_FETCH;
      endcase
   end

   always_comb begin
      ir_w      = 1'b0;
      pc_w      = 1'b0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      branch    = 1'b0;
      aluop     = 1'b0;
      adrSrc    = 1'b0;
      aluSrcA   = 1'b0;
      aluSrcB   = 2'b00;
      resultSrc = 2'b00;
      case (state)
         S_FETCH: begin
            ir_w = 1'b1; pc_w = 1'b1;
            aluSrcA = 1'b1; aluSrcB = 2'b10; resultSrc = 2'b10;
         end
         S_DECODE: begin
            aluSrcA = 1'b1; aluSrcB = 2'b10; resultSrc = 2'b10;
         end
         S_MEMADR:   aluSrcB = 2'b01;
         S_MEMREAD:  adrSrc = 1'b1;
         S_MEMWB: begin
            resultSrc = 2'b01; reg_w = 1'b1;
         end
         S_MEMWRITE: begin
            adrSrc = 1'b1; mem_w = 1'b1;
         end
         S_EXECUTER: begin
            aluSrcB = 2'b00; aluop = 1'b1;
         end
         S_EXECUTEI: begin
            aluSrcB = 2'b01; aluop = 1'b1;
         end
         S_ALUWB:    reg_w = 1'b1;
         S_BRANCH: begin
            aluSrcB = 2'b01; resultSrc = 2'b10; branch = 1'b1;
         end
         default: ;
      endcase
   end

   mc_aludec u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (aluControl),
      .flagw      (flag_w)
   );

   // Reset forces FETCH, whose strobes must not leak out while reset is held.
   assign irWrite = ir_w & reset;
   assign nextPC  = pc_w & reset;
   assign regW    = reg_w & reset;
   assign memW    = mem_w & reset;
   assign flagW   = flag_w & {2{reset}};
   assign PCS     = (((rd == 4'hF) & reg_w) | branch) & reset;

   assign immSrc = op;
   assign regSrc = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_mc_decoder.sv
// Scoreboard bench for mc_decoder: instruction-level reference model pushes
// per-cycle expectations; a negedge monitor pops and compares.
module tb_mc_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       irWrite, nextPC, regW, memW, PCS, adrSrc, aluSrcA;
   logic [1:0] flagW, aluSrcB, resultSrc, aluControl, immSrc, regSrc;

   mc_decoder #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
      .irWrite(irWrite), .nextPC(nextPC), .regW(regW), .memW(memW), .PCS(PCS),
      .flagW(flagW), .adrSrc(adrSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .resultSrc(resultSrc), .aluControl(aluControl), .immSrc(immSrc), .regSrc(regSrc)
   );

   always #5 clk = ~clk;

   typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                 P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_UNK} phase_e;

   typedef struct packed {
      logic       irWrite;
      logic       nextPC;
      logic       regW;
      logic       memW;
      logic       PCS;
      logic [1:0] flagW;
      logic       adrSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] resultSrc;
      logic [1:0] aluControl;
      logic [1:0] immSrc;
      logic [1:0] regSrc;
   } outv_t;

   outv_t exp_q[$];
   outv_t got;
   int    errors = 0;
   int    checks = 0;

   assign got = '{irWrite, nextPC, regW, memW, PCS, flagW, adrSrc, aluSrcA,
                  aluSrcB, resultSrc, aluControl, immSrc, regSrc};

   // Expected outputs for one cycle, from the phase and the inputs being driven.
   function automatic outv_t model(phase_e p, logic [1:0] o, logic [5:0] f, logic [3:0] r);
      outv_t      e;
      logic       alu, br, known;
      logic [1:0] ctl;
      e = '0; alu = 1'b0; br = 1'b0; known = 1'b1; ctl = 2'b00;
      e.immSrc = o;
      e.regSrc = {o == 2'b01, o == 2'b10};
      case (p)
         P_FETCH:    begin e.irWrite = 1; e.nextPC = 1; e.aluSrcA = 1; e.aluSrcB = 2; e.resultSrc = 2; end
         P_DECODE:   begin e.aluSrcA = 1; e.aluSrcB = 2; e.resultSrc = 2; end
         P_MEMADR:   e.aluSrcB = 1;
         P_MEMREAD:  e.adrSrc = 1;
         P_MEMWB:    begin e.resultSrc = 1; e.regW = 1; end
         P_MEMWRITE: begin e.adrSrc = 1; e.memW = 1; end
         P_EXECR:    alu = 1'b1;
         P_EXECI:    begin e.aluSrcB = 1; alu = 1'b1; end
         P_ALUWB:    e.regW = 1;
         P_BRANCH:   begin e.aluSrcB = 1; e.resultSrc = 2; br = 1'b1; end
         default: ;
      endcase
      if (alu) begin
         case (f[4:1])
            4'b0100: ctl = 2'b00;
            4'b0010: ctl = 2'b01;
            4'b0000: ctl = 2'b10;
            4'b1100: ctl = 2'b11;
            default: known = 1'b0;
         endcase
         e.aluControl = known ? ctl : 2'b00;
         e.flagW      = known ? {f[0], f[0] & (ctl < 2'd2)} : 2'b00;
      end
      e.PCS = ((r == 4'hF) && e.regW) || br;
      return e;
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         outv_t e;
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got=%05h required=%05h", $time, got, e);
         end
      end
   end

   task automatic check(string name, int actual, int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   function automatic void build_seq(logic [1:0] o, logic [5:0] f, ref phase_e seq[$]);
      seq = {P_FETCH, P_DECODE};
      case (o)
         2'b00: begin seq.push_back(f[5] ? P_EXECI : P_EXECR); seq.push_back(P_ALUWB); end
         2'b01: begin
            seq.push_back(P_MEMADR);
            if (f[0]) begin seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
            else      seq.push_back(P_MEMWRITE);
         end
         2'b10: seq.push_back(P_BRANCH);
         default: seq.push_back(P_UNK);
      endcase
   endfunction

   // One cycle: drive inputs just after the edge, queue the expectation, advance.
   task automatic drive_cycle(phase_e p, logic [1:0] o, logic [5:0] f, logic [3:0] r);
      op = o; funct = f; rd = r;
      exp_q.push_back(model(p, o, f, r));
      @(posedge clk); #1;
   endtask

   // Noise on the fields in FETCH and the final phase must not steer the FSM.
   task automatic run_instr(string name, logic [1:0] o, logic [5:0] f, logic [3:0] r, bit noise);
      phase_e seq[$];
      build_seq(o, f, seq);
      $display("instr %-6s op=%b funct=%b rd=%0d cycles=%0d", name, o, f, r, seq.size());
      foreach (seq[i]) begin
         if (noise && (i == 0 || i == seq.size() - 1))
            drive_cycle(seq[i], 2'($urandom), 6'($urandom), 4'($urandom));
         else
            drive_cycle(seq[i], o, f, r);
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_strobes"}, {irWrite, nextPC, regW, memW, PCS, flagW}, 0);
      check({tag, "_fetch_sel"}, {adrSrc, aluSrcA, aluSrcB, resultSrc}, 6'b0_1_10_10);
   endtask

   initial begin
      logic [3:0] cmds [4];
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
      reset = 1'b0; op = 2'b00; funct = 6'd0; rd = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b1;

      run_instr("ADD",   2'b00, 6'b001000, 4'd1,  1'b0);
      run_instr("SUBSI", 2'b00, 6'b100101, 4'd2,  1'b0);
      run_instr("LDR",   2'b01, 6'b011001, 4'd3,  1'b0);
      run_instr("STR",   2'b01, 6'b011000, 4'd4,  1'b0);
      run_instr("B",     2'b10, 6'b000000, 4'd0,  1'b0);
      run_instr("ADDPC", 2'b00, 6'b001000, 4'd15, 1'b0);
      run_instr("ANDS",  2'b00, 6'b000001, 4'd5,  1'b0);
      run_instr("ORRS",  2'b00, 6'b011001, 4'd6,  1'b0);
      run_instr("BADCMD",2'b00, 6'b001011, 4'd7,  1'b0);
      run_instr("UND",   2'b11, 6'b111111, 4'd15, 1'b0);
      run_instr("LDRPC", 2'b01, 6'b010001, 4'd15, 1'b1);

      // Reset asserted in the middle of MEMREAD of a load.
      $display("instr LDR-RESET op=01 funct=011001 rd=3 reset in MEMREAD");
      drive_cycle(P_FETCH,  2'b01, 6'b011001, 4'd3);
      drive_cycle(P_DECODE, 2'b01, 6'b011001, 4'd3);
      drive_cycle(P_MEMADR, 2'b01, 6'b011001, 4'd3);
      exp_q.push_back(model(P_MEMREAD, 2'b01, 6'b011001, 4'd3));
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      check_reset_outputs("heldreset");
      reset = 1'b1;

      run_instr("ADD2",  2'b00, 6'b001001, 4'd8, 1'b0);

      for (int n = 0; n < 80; n++) begin
         logic [1:0] o;
         logic [3:0] c, r;
         logic [5:0] f;
         o = 2'($urandom_range(0, 3));
         c = ($urandom_range(0, 3) != 0) ? cmds[$urandom_range(0, 3)] : 4'($urandom);
         f = {1'($urandom), c, 1'($urandom)};
         r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         run_instr("RAND", o, f, r, 1'b1);
      end

      repeat (2) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
